// File: rtl/vga_pkg.sv
// Shared widths and test-pattern mode codes for the VGA output stage.
package vga_pkg;

  localparam int PIX_X_W = 9;
  localparam int PIX_Y_W = 10;
  localparam int RGB_W   = 3;

  localparam logic [1:0] MODE_ROM   = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_MBAR  = 2'd3;

endpackage

// File: rtl/vga_delay_line.sv
// DEPTH-stage shift register with asynchronous reset to a per-bit reset value.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_output_stage.sv
// Final pixel stage: aligns syncs with ROM data, selects ROM or a test pattern,
// blanks outside the active area and counts frames.
module vga_output_stage
  import vga_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter bit SYNC_IDLE = 1'b1,
  parameter int FCNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               video_on_in,
  input  logic [PIX_X_W-1:0] pixel_x,
  input  logic [PIX_Y_W-1:0] pixel_y,
  input  logic [RGB_W-1:0]   rom_rgb,
  input  logic [1:0]         mode,
  output logic [RGB_W-1:0]   RGB,
  output logic               hsync,
  output logic               vsync,
  output logic [FCNT_W-1:0]  frame_cnt
);

  localparam int BUS_W = 3 + PIX_X_W + PIX_Y_W;
  localparam logic [BUS_W-1:0] BUS_RST =
    {SYNC_IDLE, SYNC_IDLE, 1'b0, {(PIX_X_W+PIX_Y_W){1'b0}}};

  logic               d_hsync, d_vsync, d_video_on;
  logic [PIX_X_W-1:0] dx;
  logic [PIX_Y_W-1:0] dy;

  // Sync, blank and coords travel together so they stay aligned with rom_rgb.
  vga_delay_line #(
    .W       (BUS_W),
    .DEPTH   (RD_LAT),
    .RST_VAL (BUS_RST)
  ) u_dly (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   ({hsync_in, vsync_in, video_on_in, pixel_x, pixel_y}),
    .q_o   ({d_hsync, d_vsync, d_video_on, dx, dy})
  );

  logic              vs_prev_q;
  logic              frame_start;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic [1:0]        mode_act_q;
  logic [RGB_W-1:0]  colour_d, rgb_d, rgb_q;
  logic              hsync_q, vsync_q;

  assign frame_start = (vs_prev_q == SYNC_IDLE) && (vsync_in != SYNC_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev_q   <= SYNC_IDLE;
      frame_cnt_q <= '0;
      mode_act_q  <= MODE_ROM;
    end else begin
      vs_prev_q <= vsync_in;
      if (frame_start) begin
        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
        mode_act_q  <= mode;
      end
    end
  end

  always_comb begin
    colour_d = rom_rgb;
    case (mode_act_q)
      MODE_ROM:   colour_d = rom_rgb;
      MODE_BARS:  colour_d = dx[8:6];
      MODE_CHECK: colour_d = {RGB_W{dx[4] ^ dy[4]}};
      MODE_MBAR:  colour_d = (dx[8:3] == frame_cnt_q[5:0]) ? 3'b111 : 3'b001;
      default:    colour_d = rom_rgb;
    endcase
  end

  assign rgb_d = d_video_on ? colour_d : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q   <= '0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= d_hsync;
      vsync_q <= d_vsync;
    end
  end

  // Low coord bits not consumed by any pattern.
  logic unused_coords;
  assign unused_coords = ^{dx[2:0], dy[PIX_Y_W-1:5], dy[3:0]};

  assign RGB       = rgb_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_output_stage.sv
// Bench for vga_output_stage: per-cycle model compare plus directed literal checks.
module tb_vga_output_stage;

  localparam int RD_LAT = 2;
  localparam int LAT    = RD_LAT + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hsync_in = 1'b1, vsync_in = 1'b1, video_on_in = 1'b0;
  logic [8:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [2:0] rom_rgb = '0;
  logic [1:0] mode = '0;
  logic [2:0] RGB;
  logic       hsync, vsync;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  vga_output_stage #(.RD_LAT(RD_LAT), .SYNC_IDLE(1'b1), .FCNT_W(8)) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .video_on_in(video_on_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .rom_rgb(rom_rgb), .mode(mode), .RGB(RGB), .hsync(hsync), .vsync(vsync),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side ROM: answers RD_LAT cycles after the address.
  logic [8:0] xh [4];
  bit         rom_fixed_en = 1'b0;
  logic [2:0] rom_fixed = '0;

  function automatic logic [2:0] rom_fn(input logic [8:0] x);
    return (x == 0) ? 3'b101 : (x[2:0] ^ 3'b110);
  endfunction

  task automatic step();
    rom_rgb = rom_fixed_en ? rom_fixed : rom_fn(xh[RD_LAT-1]);
    @(posedge clk);
    for (int i = 3; i > 0; i--) xh[i] = xh[i-1];
    xh[0] = pixel_x;
    #1;
  endtask

  // Reference model: history of controller samples and pattern rules in plain arithmetic.
  typedef struct {
    logic       hs, vs, von;
    logic [8:0] x;
    logic [9:0] y;
  } smp_t;

  smp_t       hist[$];
  smp_t       s, k;
  int         m_fc = 0;
  int         m_mode = 0;
  logic       m_prev_vs = 1'b1;
  logic [2:0] e_rgb = '0;
  logic       e_hs = 1'b1, e_vs = 1'b1;

  function automatic logic [2:0] pattern(input int md, input int fc, input logic [2:0] rom,
                                         input int x, input int y);
    case (md)
      1:       return 3'(x / 64);
      2:       return (((x / 16) + (y / 16)) % 2 == 1) ? 3'b111 : 3'b000;
      3:       return ((x / 8) == (fc % 64)) ? 3'b111 : 3'b001;
      default: return rom;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      m_fc = 0; m_mode = 0; m_prev_vs = 1'b1;
      e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1;
    end else begin
      s = '{hs: hsync_in, vs: vsync_in, von: video_on_in, x: pixel_x, y: pixel_y};
      hist.push_front(s);
      if (hist.size() > LAT) void'(hist.pop_back());
      if (hist.size() == LAT) begin
        k     = hist[RD_LAT];
        e_hs  = k.hs;
        e_vs  = k.vs;
        e_rgb = k.von ? pattern(m_mode, m_fc, rom_rgb, int'(k.x), int'(k.y)) : 3'b000;
      end
      if (m_prev_vs && !vsync_in) begin
        m_fc   = (m_fc + 1) % 256;
        m_mode = int'(mode);
      end
      m_prev_vs = vsync_in;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model_rgb",   RGB,       e_rgb);
      check("model_hsync", hsync,     e_hs);
      check("model_vsync", vsync,     e_vs);
      check("model_fcnt",  frame_cnt, m_fc);
    end
  end

  task automatic idle_inputs();
    hsync_in = 1'b1; vsync_in = 1'b1; video_on_in = 1'b0;
    pixel_x = '0; pixel_y = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0; step();
    vsync_in = 1'b1; step();
  endtask

  task automatic probe(input string name, input logic [8:0] x, input logic [9:0] y,
                       input logic [2:0] exp);
    pixel_x = x; pixel_y = y; video_on_in = 1'b1;
    repeat (LAT) step();
    check(name, RGB, exp);
    video_on_in = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) xh[i] = '0;
    do_reset();

    // Async reset in the middle of an hsync pulse
    vsync_pulse();
    rom_fixed_en = 1'b1; rom_fixed = 3'b111;
    video_on_in = 1'b1; hsync_in = 1'b0;
    repeat (4) step();
    check("pre_rst_hsync", hsync, 1'b0);
    check("pre_rst_rgb",   RGB, 3'b111);
    check("pre_rst_fcnt",  frame_cnt, 8'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_rgb",   RGB, 3'b000);
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_fcnt",  frame_cnt, 8'd0);
    rom_fixed_en = 1'b0;
    do_reset();

    // Alignment: hsync_in low 10..105 must show low 13..108
    for (int i = 0; i < 116; i++) begin
      hsync_in    = (i >= 10 && i <= 105) ? 1'b0 : 1'b1;
      pixel_x     = 9'(i - 20);
      video_on_in = 1'b1;
      step();
      case (i + 1)
        12:  check("hs_before", hsync, 1'b1);
        13:  check("hs_first",  hsync, 1'b0);
        108: check("hs_last",   hsync, 1'b0);
        109: check("hs_after",  hsync, 1'b1);
        23:  check("rom_x0",    RGB, 3'b101);
        default: ;
      endcase
    end
    idle_inputs();
    do_reset();

    // Blanking with ROM data held
    rom_fixed_en = 1'b1; rom_fixed = 3'b111;
    pixel_x = 9'd5;
    repeat (6) step();
    check("blank_rgb", RGB, 3'b000);
    video_on_in = 1'b1;
    repeat (LAT - 1) step();
    check("unblank_early", RGB, 3'b000);
    step();
    check("unblank_rgb", RGB, 3'b111);
    rom_fixed_en = 1'b0;
    do_reset();

    // Mode latches only at frame start
    mode = 2'd1;
    probe("midframe_rom", 9'h040, 10'd0, 3'b110);
    vsync_pulse();
    probe("bars_x40",  9'h040, 10'd0, 3'b001);
    probe("bars_x7f",  9'h07F, 10'd0, 3'b001);
    probe("bars_x1c0", 9'h1C0, 10'd0, 3'b111);

    // Frame counter wrap and moving bar
    do_reset();
    mode = 2'd3;
    repeat (256) vsync_pulse();
    check("fcnt_wrap", frame_cnt, 8'd0);
    repeat (5) vsync_pulse();
    check("fcnt_5", frame_cnt, 8'd5);
    probe("mbar_39", 9'd39, 10'd3, 3'b001);
    probe("mbar_40", 9'd40, 10'd3, 3'b111);
    probe("mbar_47", 9'd47, 10'd3, 3'b111);
    probe("mbar_48", 9'd48, 10'd3, 3'b001);

    // Checkerboard
    mode = 2'd2;
    vsync_pulse();
    probe("chk_16_0",  9'd16, 10'd0,  3'b111);
    probe("chk_16_16", 9'd16, 10'd16, 3'b000);
    probe("chk_0_16",  9'd0,  10'd16, 3'b111);

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
